// File: rtl/gusn_pkg.sv
// ---------------------------------------------------------------------------
// gusn_pkg
// Shared definitions for the perceptron front end: image geometry, the
// frame assembler state encoding and two reference test images.
// Optional feature used by the assembler: FRAME_DBUF_EN (shadow buffer).
// ---------------------------------------------------------------------------
package gusn_pkg;

    localparam int ROW_W   = 5;
    localparam int ROWS    = 5;
    localparam int FRAME_W = ROWS * ROW_W;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Row 0 sits in the top bits, leftmost pixel is the row MSB.
    localparam logic [FRAME_W-1:0] CROSS_IMG  = 25'h1151151;
    localparam logic [FRAME_W-1:0] CIRCLE_IMG = 25'h0454544;

endpackage

// File: rtl/row_shift_reg.sv
// ---------------------------------------------------------------------------
// row_shift_reg
// ROWS-deep shift register of ROW_W-bit rows. New rows enter at the bottom,
// so after ROWS shifts the first row shifted in occupies the top bits.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       zero the register (highest priority)
//   load        parallel load of load_data
//   load_data   value for a parallel load
//   shift       shift row_in in at the bottom
//   row_in      row to shift in
//   data        current register contents
// ---------------------------------------------------------------------------
module row_shift_reg #(
    parameter int ROW_W = gusn_pkg::ROW_W,
    parameter int ROWS  = gusn_pkg::ROWS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     load,
    input  logic [ROWS*ROW_W-1:0]    load_data,
    input  logic                     shift,
    input  logic [ROW_W-1:0]         row_in,
    output logic [ROWS*ROW_W-1:0]    data
);

    localparam int FW = ROWS * ROW_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= {data[FW-ROW_W-1:0], row_in};
        end
    end

endmodule

// File: rtl/frame_assembler.sv
// ---------------------------------------------------------------------------
// frame_assembler
// Collects a ROWS x ROW_W binary image one row per valid/ready transfer and
// presents it to the perceptron, held stable with frame_en high until the
// perceptron pulses frame_ready.
// Optional feature: define FRAME_DBUF_EN to add a shadow assembly buffer so
// the next frame can be collected while the current one is presented.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   row_data     pixel row, MSB = leftmost pixel
//   row_valid    row_data / row_sof valid
//   row_sof      marks row 0 of a frame
//   row_ready    a row can be accepted this cycle
//   frame        assembled image, row 0 in the top bits
//   frame_en     frame valid and held
//   frame_ready  perceptron has consumed the frame
//   sof_err      one-cycle pulse on a framing error
//   frame_cnt    number of consumed frames (wraps)
// ---------------------------------------------------------------------------
module frame_assembler #(
    parameter int ROW_W = gusn_pkg::ROW_W,
    parameter int ROWS  = gusn_pkg::ROWS,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ROW_W-1:0]         row_data,
    input  logic                     row_valid,
    input  logic                     row_sof,
    output logic                     row_ready,
    output logic [ROWS*ROW_W-1:0]    frame,
    output logic                     frame_en,
    input  logic                     frame_ready,
    output logic                     sof_err,
    output logic [CNT_W-1:0]         frame_cnt
);

    import gusn_pkg::*;

    localparam int FW    = ROWS * ROW_W;
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t           state;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] idx_next;
    logic             accept;
    logic             row_done;
    logic             framing_err;
    logic             asm_shift;
    logic             asm_load;
    logic [FW-1:0]    asm_q;
    logic [FW-1:0]    asm_next;
    logic [FW-1:0]    restart_data;

    assign accept       = row_valid & row_ready;
    assign asm_next     = {asm_q[FW-ROW_W-1:0], row_data};
    assign restart_data = {{(FW-ROW_W){1'b0}}, row_data};

    // Framing decisions for an accepted row. A stray sof restarts the frame
    // with this row as row 0; a missing sof at row 0 drops the row. The
    // completing row is never written to the assembly register: it is merged
    // on the fly into asm_next and the register is cleared for the next frame.
    always_comb begin
        idx_next    = row_idx;
        row_done    = 1'b0;
        framing_err = 1'b0;
        asm_shift   = 1'b0;
        asm_load    = 1'b0;
        if (accept) begin
            if (row_sof && (row_idx != '0)) begin
                framing_err = 1'b1;
                asm_load    = 1'b1;
                idx_next    = IDX_W'(1);
            end else if (!row_sof && (row_idx == '0)) begin
                framing_err = 1'b1;
            end else if (row_idx == IDX_W'(ROWS-1)) begin
                row_done    = 1'b1;
                idx_next    = '0;
            end else begin
                asm_shift   = 1'b1;
                idx_next    = row_idx + IDX_W'(1);
            end
        end
    end

    row_shift_reg #(
        .ROW_W(ROW_W),
        .ROWS (ROWS)
    ) u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (row_done),
        .load     (asm_load),
        .load_data(restart_data),
        .shift    (asm_shift),
        .row_in   (row_data),
        .data     (asm_q)
    );

`ifdef FRAME_DBUF_EN
    logic          shadow_full;
    logic          shadow_load;
    logic [FW-1:0] shadow_q;
    logic [FW-1:0] shadow_src;

    // A frame completed while presenting goes to the shadow. If the handshake
    // lands on the completing edge, the merged frame bypasses the shadow.
    assign shadow_load = row_done && (state == PRESENT);
    assign shadow_src  = shadow_full ? shadow_q : asm_next;

    row_shift_reg #(
        .ROW_W(ROW_W),
        .ROWS (ROWS)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (1'b0),
        .load     (shadow_load),
        .load_data(asm_next),
        .shift    (1'b0),
        .row_in   ({ROW_W{1'b0}}),
        .data     (shadow_q)
    );
`endif

    // Main FSM with registered outputs. row_ready comes up on the first edge
    // after reset because COLLECT re-asserts it every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            row_idx     <= '0;
            frame       <= '0;
            frame_en    <= 1'b0;
            row_ready   <= 1'b0;
            sof_err     <= 1'b0;
            frame_cnt   <= '0;
`ifdef FRAME_DBUF_EN
            shadow_full <= 1'b0;
`endif
        end else begin
            row_idx <= idx_next;
            sof_err <= framing_err;
            case (state)
                COLLECT: begin
                    row_ready <= 1'b1;
                    if (row_done) begin
                        frame    <= asm_next;
                        frame_en <= 1'b1;
                        state    <= PRESENT;
`ifndef FRAME_DBUF_EN
                        row_ready <= 1'b0;
`endif
                    end
                end
                PRESENT: begin
`ifdef FRAME_DBUF_EN
                    if (frame_ready) begin
                        frame_cnt   <= frame_cnt + CNT_W'(1);
                        row_ready   <= 1'b1;
                        shadow_full <= 1'b0;
                        if (shadow_full || shadow_load) begin
                            frame <= shadow_src;
                        end else begin
                            frame_en <= 1'b0;
                            state    <= COLLECT;
                        end
                    end else if (shadow_load) begin
                        shadow_full <= 1'b1;
                        row_ready   <= 1'b0;
                    end
`else
                    if (frame_ready) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        frame_en  <= 1'b0;
                        row_ready <= 1'b1;
                        state     <= COLLECT;
                    end
`endif
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
